// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline stall/flush controller
package pipe_ctrl_pkg;
  localparam int MEM_TIMEOUT_DEF = 15;
  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
  } ctrl_t;
  localparam ctrl_t CTRL_RUN   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_STALL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t CTRL_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_LU    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose nonzero destination feeds the instruction in ID
// Ports: id_rs1/id_rs2 ID sources, id_ex_memread/id_ex_rd EX load info, hazard result.
module load_use_detect #(
  parameter int RF_ADDR_W = 5
) (
  input  logic [RF_ADDR_W-1:0] id_rs1,
  input  logic [RF_ADDR_W-1:0] id_rs2,
  input  logic                 id_ex_memread,
  input  logic [RF_ADDR_W-1:0] id_ex_rd,
  output logic                 hazard
);
  assign hazard = id_ex_memread && (id_ex_rd != '0) && (id_ex_rd == id_rs1 || id_ex_rd == id_rs2);
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush controller for the five-stage pipeline registers
// Ports: clk, reset (sync, active-high); hazard inputs id_rs1, id_rs2, id_ex_memread, id_ex_rd,
// ex_mem_memread, ex_mem_memwrite, dmem_ready, branch_taken; outputs pc_en, if_id_en, id_ex_en,
// ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble, mem_fault (sticky).
// STALL_PERF_CNT_EN adds 32-bit stall_cycles and flush_count counters.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int RF_ADDR_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [RF_ADDR_W-1:0] id_rs1,
  input  logic [RF_ADDR_W-1:0] id_rs2,
  input  logic                 id_ex_memread,
  input  logic [RF_ADDR_W-1:0] id_ex_rd,
  input  logic                 ex_mem_memread,
  input  logic                 ex_mem_memwrite,
  input  logic                 dmem_ready,
  input  logic                 branch_taken,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 id_ex_en,
  output logic                 ex_mem_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 mem_wb_bubble,
  output logic                 mem_fault
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_count
`endif
);
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
  state_t     state, state_n;
  logic [7:0] wait_cnt, cnt_n;
  ctrl_t      ctrl;
  logic       fault, load_use;
  wire        mem_busy = (ex_mem_memread || ex_mem_memwrite) && !dmem_ready;
  load_use_detect #(.RF_ADDR_W(RF_ADDR_W)) u_lud (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_ex_memread(id_ex_memread),
    .id_ex_rd     (id_ex_rd),
    .hazard       (load_use)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= cnt_n;
    end
  end
  // In MEM_WAIT the ready cycle only releases the freeze; a held branch flushes on the following RUN cycle.
  always_comb begin
    ctrl    = CTRL_RUN;
    fault   = 1'b0;
    state_n = state;
    cnt_n   = wait_cnt;
    case (state)
      RUN: begin
        if (mem_busy) begin
          ctrl    = CTRL_STALL;
          state_n = MEM_WAIT;
          cnt_n   = 8'd1;
        end else begin
          ctrl = branch_taken ? CTRL_FLUSH : load_use ? CTRL_LU : CTRL_RUN;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          ctrl    = CTRL_STALL;
          state_n = (wait_cnt == TIMEOUT) ? FAULT : MEM_WAIT;
          cnt_n   = (wait_cnt == 8'hff) ? wait_cnt : wait_cnt + 8'd1;
        end
      end
      FAULT: begin
        ctrl  = CTRL_STALL;
        fault = 1'b1;
      end
      default: state_n = RUN;
    endcase
  end
  // Reset forces the free-running defaults regardless of the registered state.
  assign {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble} = reset ? CTRL_RUN : ctrl;
  assign mem_fault = !reset && fault;
`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en && (state == RUN || state == MEM_WAIT)) stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush) flush_count <= flush_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed self-checking bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic       id_ex_memread, ex_mem_memread, ex_mem_memwrite, dmem_ready, branch_taken;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble, mem_fault;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count, fc0, sc0;
`endif
  int n_chk = 0;
  int n_fail = 0;
  localparam logic [7:0] RUNV   = 8'b1111_0000;
  localparam logic [7:0] STALLV = 8'b0000_0010;
  localparam logic [7:0] FLUSHV = 8'b1111_1100;
  localparam logic [7:0] LUV    = 8'b0011_0100;
  localparam logic [7:0] FAULTV = 8'b0000_0011;
  wire [7:0] ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble, mem_fault};
  always #5 clk = ~clk;
  pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .RF_ADDR_W(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_ex_memread  (id_ex_memread),
    .id_ex_rd       (id_ex_rd),
    .ex_mem_memread (ex_mem_memread),
    .ex_mem_memwrite(ex_mem_memwrite),
    .dmem_ready     (dmem_ready),
    .branch_taken   (branch_taken),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .id_ex_en       (id_ex_en),
    .ex_mem_en      (ex_mem_en),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .mem_wb_bubble  (mem_wb_bubble),
    .mem_fault      (mem_fault)
`ifdef STALL_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_ex_rd = '0; id_ex_memread = 1'b0;
    ex_mem_memread = 1'b0; ex_mem_memwrite = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
  endtask
  initial begin
    idle();
    reset = 1'b1;
    ex_mem_memread = 1'b1;
    branch_taken = 1'b1;
    #2 check("reset_out", {24'd0, ctl}, {24'd0, RUNV});
    tick(); tick();
    reset = 1'b0;
    idle();
    #1 check("idle_run", {24'd0, ctl}, {24'd0, RUNV});
    id_ex_memread = 1'b1; id_ex_rd = 5'd5; id_rs2 = 5'd5;
    #1 check("lu_rs2", {24'd0, ctl}, {24'd0, LUV});
    tick(); idle();
    #1 check("lu_after", {24'd0, ctl}, {24'd0, RUNV});
    id_ex_memread = 1'b1; id_ex_rd = 5'd9; id_rs1 = 5'd9;
    #1 check("lu_rs1", {24'd0, ctl}, {24'd0, LUV});
    tick(); idle();
    id_ex_memread = 1'b1; id_ex_rd = 5'd0; id_rs1 = 5'd0;
    #1 check("lu_x0", {24'd0, ctl}, {24'd0, RUNV});
    id_ex_memread = 1'b0; id_ex_rd = 5'd7; id_rs1 = 5'd7;
    #1 check("lu_noload", {24'd0, ctl}, {24'd0, RUNV});
    tick(); idle();
    ex_mem_memread = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("memwait_%0d", i), {24'd0, ctl}, {24'd0, STALLV});
      tick();
    end
    dmem_ready = 1'b1;
    #1 check("mem_resume", {24'd0, ctl}, {24'd0, RUNV});
    tick(); idle();
    #1 check("after_resume", {24'd0, ctl}, {24'd0, RUNV});
    ex_mem_memwrite = 1'b1; dmem_ready = 1'b1;
    #1 check("zero_wait", {24'd0, ctl}, {24'd0, RUNV});
    tick(); idle();
    branch_taken = 1'b1; id_ex_memread = 1'b1; id_ex_rd = 5'd5; id_rs1 = 5'd5;
    #1 check("br_lu", {24'd0, ctl}, {24'd0, FLUSHV});
    tick(); idle();
`ifdef STALL_PERF_CNT_EN
    fc0 = flush_count; sc0 = stall_cycles;
`endif
    ex_mem_memread = 1'b1; branch_taken = 1'b1; id_ex_memread = 1'b1; id_ex_rd = 5'd3; id_rs2 = 5'd3;
    #1 check("br_mem0", {24'd0, ctl}, {24'd0, STALLV});
    tick();
    #1 check("br_mem1", {24'd0, ctl}, {24'd0, STALLV});
    tick();
    dmem_ready = 1'b1;
    #1 check("br_mem_ready", {24'd0, ctl}, {24'd0, RUNV});
    tick();
    ex_mem_memread = 1'b0; dmem_ready = 1'b0;
    #1 check("br_resume_flush", {24'd0, ctl}, {24'd0, FLUSHV});
    tick(); idle();
    #1 check("br_done", {24'd0, ctl}, {24'd0, RUNV});
`ifdef STALL_PERF_CNT_EN
    check("flush_cnt_delta", flush_count - fc0, 32'd1);
    check("stall_cnt_delta", stall_cycles - sc0, 32'd2);
`endif
    ex_mem_memread = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check($sformatf("to_wait_%0d", i), {24'd0, ctl}, {24'd0, STALLV});
      tick();
    end
    #1 check("to_fault", {24'd0, ctl}, {24'd0, FAULTV});
    idle(); dmem_ready = 1'b1;
    tick();
    #1 check("fault_sticky", {24'd0, ctl}, {24'd0, FAULTV});
    tick();
    #1 check("fault_sticky2", {31'd0, mem_fault}, 32'd1);
    reset = 1'b1;
    #1 check("fault_in_reset", {24'd0, ctl}, {24'd0, RUNV});
    tick();
    reset = 1'b0; idle();
    #1 check("post_reset_run", {24'd0, ctl}, {24'd0, RUNV});
    id_ex_memread = 1'b1; id_ex_rd = 5'd12; id_rs2 = 5'd12;
    #1 check("post_reset_lu", {24'd0, ctl}, {24'd0, LUV});
`ifdef STALL_PERF_CNT_EN
    check("perf_reset_fc", flush_count, 32'd0);
`endif
    tick(); idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
